// File: rtl/alto_dns_control_pkg.sv
// Shared encodings for the Alto NOVA-style DNS (arith/shift/skip) control slice:
// FSM states, carry-control and skip codes, and the base-carry helper.
package alto_dns_control_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ARMED  = 2'd1;
    localparam logic [1:0] ST_COMMIT = 2'd2;

    localparam logic [1:0] CRY_KEEP  = 2'b00;
    localparam logic [1:0] CRY_ZERO  = 2'b01;
    localparam logic [1:0] CRY_ONE   = 2'b10;
    localparam logic [1:0] CRY_INV   = 2'b11;

    localparam logic [1:0] SH_NONE   = 2'b00;
    localparam logic [1:0] SH_LEFT   = 2'b01;
    localparam logic [1:0] SH_RIGHT  = 2'b10;
    localparam logic [1:0] SH_SWAP   = 2'b11;

    localparam logic [2:0] SKP_NEVER = 3'b000;
    localparam logic [2:0] SKP_ALWAYS = 3'b001;
    localparam logic [2:0] SKP_NC    = 3'b010;
    localparam logic [2:0] SKP_C     = 3'b011;
    localparam logic [2:0] SKP_Z     = 3'b100;
    localparam logic [2:0] SKP_NZ    = 3'b101;
    localparam logic [2:0] SKP_NC_Z  = 3'b110;
    localparam logic [2:0] SKP_C_NZ  = 3'b111;

    function automatic logic base_carry(input logic [1:0] ctl, input logic c);
        logic b;
        case (ctl)
            CRY_KEEP: b = c;
            CRY_ZERO: b = 1'b0;
            CRY_ONE:  b = 1'b1;
            CRY_INV:  b = ~c;
            default:  b = c;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/alto_dns_skip.sv
// Combinational skip-condition evaluator on the new carry (cn) and result-zero (z).
module alto_dns_skip
    import alto_dns_control_pkg::*;
(
    input  logic [2:0] skip_code,
    input  logic       cn,
    input  logic       z,
    output logic       skip
);

    // Decode the 3-bit skip field against the freshly computed flags
    always_comb begin
        skip = 1'b0;
        case (skip_code)
            SKP_NEVER:  skip = 1'b0;
            SKP_ALWAYS: skip = 1'b1;
            SKP_NC:     skip = ~cn;
            SKP_C:      skip = cn;
            SKP_Z:      skip = z;
            SKP_NZ:     skip = ~z;
            SKP_NC_Z:   skip = ~cn | z;
            SKP_C_NZ:   skip = cn & ~z;
            default:    skip = 1'b0;
        endcase
    end

endmodule

// File: rtl/alto_dns_control.sv
// DNS sequencing: latches the instruction fields, drives the shifter carry/mode,
// and commits carry, load enable and skip one cycle after the shifter step.
module alto_dns_control
    import alto_dns_control_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic [15:0] ir_i,
    input  logic        dns_start_i,
    input  logic        dns_step_i,
    input  logic        alu_carry_i,
    input  logic        shifter_carry_i,
    input  logic [15:0] result_i,
    input  logic        carry_wr_i,
    input  logic        carry_d_i,
    output logic        carry_o,
    output logic        dns_o,
    output logic [1:0]  shift_sel_o,
    output logic        load_o,
    output logic        skip_o,
    output logic        done_o,
    output logic        busy_o,
    output logic        carry_q_o
);

    logic [1:0] state_r;
    logic [1:0] shift_sel_r;
    logic [1:0] carry_ctl_r;
    logic       no_load_r;
    logic [2:0] skip_code_r;
    logic       null_r;
    logic       new_carry_r;
    logic       carry_q_r;
    logic       load_r;
    logic       skip_r;
    logic       done_r;
    logic       zero_s;
    logic       skip_s;

    assign zero_s = (result_i == 16'h0000);

    alto_dns_skip u_skip (
        .skip_code (skip_code_r),
        .cn        (shifter_carry_i),
        .z         (zero_s),
        .skip      (skip_s)
    );

    // Sequencer, field latches, commit flags and architectural carry
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_r     <= ST_IDLE;
            shift_sel_r <= 2'b00;
            carry_ctl_r <= 2'b00;
            no_load_r   <= 1'b0;
            skip_code_r <= 3'b000;
            null_r      <= 1'b0;
            new_carry_r <= 1'b0;
            carry_q_r   <= 1'b0;
            load_r      <= 1'b0;
            skip_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    load_r <= 1'b0;
                    skip_r <= 1'b0;
                    if (carry_wr_i) begin
                        carry_q_r <= carry_d_i;
                    end
                    if (dns_start_i && ir_i[15]) begin
                        shift_sel_r <= ir_i[7:6];
                        carry_ctl_r <= ir_i[5:4];
                        no_load_r   <= ir_i[3];
                        skip_code_r <= ir_i[2:0];
                        null_r      <= 1'b0;
                        done_r      <= 1'b0;
                        state_r     <= ST_ARMED;
                    end else if (dns_start_i) begin
                        // Non-arithmetic instruction: complete with no side effects
                        null_r  <= 1'b1;
                        done_r  <= 1'b1;
                        state_r <= ST_COMMIT;
                    end else begin
                        done_r <= 1'b0;
                    end
                end
                ST_ARMED: begin
                    if (dns_step_i) begin
                        new_carry_r <= shifter_carry_i;
                        load_r      <= ~no_load_r;
                        skip_r      <= skip_s;
                        done_r      <= 1'b1;
                        state_r     <= ST_COMMIT;
                    end else begin
                        done_r <= 1'b0;
                    end
                end
                ST_COMMIT: begin
                    if (!null_r && !no_load_r) begin
                        carry_q_r <= new_carry_r;
                    end
                    load_r      <= 1'b0;
                    skip_r      <= 1'b0;
                    done_r      <= 1'b0;
                    null_r      <= 1'b0;
                    shift_sel_r <= 2'b00;
                    carry_ctl_r <= 2'b00;
                    no_load_r   <= 1'b0;
                    skip_code_r <= 3'b000;
                    state_r     <= ST_IDLE;
                end
                default: begin
                    done_r  <= 1'b0;
                    load_r  <= 1'b0;
                    skip_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    // Shifter-facing carry and mode; the ALU carry folds in only while armed
    always_comb begin
        carry_o = carry_q_r;
        dns_o   = 1'b0;
        if (state_r == ST_ARMED) begin
            carry_o = base_carry(carry_ctl_r, carry_q_r) ^ alu_carry_i;
            dns_o   = 1'b1;
        end else begin
            carry_o = carry_q_r;
            dns_o   = 1'b0;
        end
    end

    assign shift_sel_o = shift_sel_r;
    assign load_o      = load_r;
    assign skip_o      = skip_r;
    assign done_o      = done_r;
    assign busy_o      = (state_r != ST_IDLE);
    assign carry_q_o   = carry_q_r;

endmodule

// File: tb/tb_alto_dns_control.sv
// Directed self-checking bench for alto_dns_control with hand-computed expectations.
module tb_alto_dns_control;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] ir = 16'h0000;
    logic        start = 1'b0;
    logic        step = 1'b0;
    logic        alu_c = 1'b0;
    logic        sh_c = 1'b0;
    logic [15:0] result = 16'h0000;
    logic        c_wr = 1'b0;
    logic        c_d = 1'b0;
    logic        carry_o, dns_o, load_o, skip_o, done_o, busy_o, carry_q_o;
    logic [1:0]  shift_sel_o;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    alto_dns_control dut (
        .clk_i           (clk),
        .rst_n_i         (rst_n),
        .ir_i            (ir),
        .dns_start_i     (start),
        .dns_step_i      (step),
        .alu_carry_i     (alu_c),
        .shifter_carry_i (sh_c),
        .result_i        (result),
        .carry_wr_i      (c_wr),
        .carry_d_i       (c_d),
        .carry_o         (carry_o),
        .dns_o           (dns_o),
        .shift_sel_o     (shift_sel_o),
        .load_o          (load_o),
        .skip_o          (skip_o),
        .done_o          (done_o),
        .busy_o          (busy_o),
        .carry_q_o       (carry_q_o)
    );

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic arm(input logic [15:0] instr);
        ir = instr;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic do_step(input logic cn, input logic [15:0] res);
        step = 1'b1;
        sh_c = cn;
        result = res;
        tick();
        step = 1'b0;
    endtask

    initial begin
        tick();
        tick();
        check("rst_busy", busy_o, 16'd0);
        check("rst_done", done_o, 16'd0);
        check("rst_load", load_o, 16'd0);
        check("rst_skip", skip_o, 16'd0);
        check("rst_cq", carry_q_o, 16'd0);
        check("rst_sel", shift_sel_o, 16'd0);
        check("rst_dns", dns_o, 16'd0);
        rst_n = 1'b1;
        tick();

        // Carry ctl 10 (base 1) xor ALU carry
        arm(16'h8020);
        check("a_busy", busy_o, 16'd1);
        check("a_dns", dns_o, 16'd1);
        alu_c = 1'b1; #1;
        check("a_cy_alu1", carry_o, 16'd0);
        alu_c = 1'b0; #1;
        check("a_cy_alu0", carry_o, 16'd1);
        alu_c = 1'b1;
        do_step(1'b0, 16'h1234);
        check("a_done", done_o, 16'd1);
        check("a_load", load_o, 16'd1);
        check("a_skip", skip_o, 16'd0);
        check("a_dns_commit", dns_o, 16'd0);
        check("a_cy_commit", carry_o, 16'd0);
        tick();
        check("a_done_clr", done_o, 16'd0);
        check("a_busy_clr", busy_o, 16'd0);
        check("a_cq", carry_q_o, 16'd0);

        // Shift L, skip on Cn=0, new carry 1
        alu_c = 1'b0;
        arm(16'h8042);
        check("b_sel", shift_sel_o, 16'd1);
        check("b_cy", carry_o, 16'd0);
        tick();
        check("b_wait_done", done_o, 16'd0);
        do_step(1'b1, 16'h0000);
        check("b_done", done_o, 16'd1);
        check("b_skip", skip_o, 16'd0);
        check("b_load", load_o, 16'd1);
        tick();
        check("b_cq", carry_q_o, 16'd1);
        check("b_done_clr", done_o, 16'd0);

        // No-load, skip on Z: carry kept despite new carry 0
        arm(16'h800C);
        do_step(1'b0, 16'h0000);
        check("c_skip", skip_o, 16'd1);
        check("c_load", load_o, 16'd0);
        tick();
        check("c_cq", carry_q_o, 16'd1);

        // Null (non-arith) instruction
        arm(16'h0000);
        check("d_done", done_o, 16'd1);
        check("d_load", load_o, 16'd0);
        check("d_skip", skip_o, 16'd0);
        tick();
        check("d_done_clr", done_o, 16'd0);
        check("d_cq", carry_q_o, 16'd1);

        // Step in IDLE is ignored
        do_step(1'b0, 16'h0000);
        check("e_idle_step", done_o, 16'd0);

        // Second start while armed is ignored; skip-always
        arm(16'h8001);
        arm(16'h8FC7);
        check("f_sel_kept", shift_sel_o, 16'd0);
        check("f_busy", busy_o, 16'd1);
        do_step(1'b1, 16'h0005);
        check("f_skip", skip_o, 16'd1);
        tick();

        // Skip codes 111 and 110
        arm(16'h8007);
        do_step(1'b1, 16'h0001);
        check("g_skip111", skip_o, 16'd1);
        tick();
        arm(16'h8006);
        do_step(1'b1, 16'h0007);
        check("h_skip110", skip_o, 16'd0);
        tick();

        // Carry ctl 11 (~C) with C=1; direct write ignored while armed; reset mid-op
        arm(16'h8030);
        alu_c = 1'b0; #1;
        check("i_cy_inv0", carry_o, 16'd0);
        alu_c = 1'b1; #1;
        check("i_cy_inv1", carry_o, 16'd1);
        c_wr = 1'b1;
        c_d = 1'b0;
        tick();
        c_wr = 1'b0;
        check("i_wr_armed", carry_q_o, 16'd1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("j_rst_busy", busy_o, 16'd0);
        check("j_rst_cq", carry_q_o, 16'd0);
        check("j_rst_sel", shift_sel_o, 16'd0);
        c_wr = 1'b1;
        c_d = 1'b1;
        tick();
        c_wr = 1'b0;
        check("j_wr_idle", carry_q_o, 16'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
